// File: rtl/capp_tag_unit_if.sv
// rtl/capp_tag_unit_if.sv - Tag unit bus: tag ops, tag status and iterator handshake
interface capp_tag_unit_if #(
  parameter int NUM_CELLS = 100,
  parameter int IDX_W     = 7,
  parameter int CNT_W     = 8
);
  logic [NUM_CELLS-1:0] match_lines;
  logic                 op_valid;
  logic [2:0]           op;
  logic [NUM_CELLS-1:0] tags;
  logic                 some;
  logic                 none;
  logic [IDX_W-1:0]     first_idx;
  logic [CNT_W-1:0]     tag_count;
  logic                 iter_start;
  logic                 iter_valid;
  logic                 iter_ready;
  logic [IDX_W-1:0]     iter_idx;
  logic                 iter_done;
  logic                 busy;

  // Controller side
  modport master (
    output match_lines, op_valid, op, iter_start, iter_ready,
    input  tags, some, none, first_idx, tag_count,
           iter_valid, iter_idx, iter_done, busy
  );

  // Tag unit side
  modport slave (
    input  match_lines, op_valid, op, iter_start, iter_ready,
    output tags, some, none, first_idx, tag_count,
           iter_valid, iter_idx, iter_done, busy
  );
endinterface

// File: rtl/capp_tag_unit.sv
// rtl/capp_tag_unit.sv - Tag register bank with tag ops, status reduction and ascending index iterator
module capp_tag_unit #(
  parameter int NUM_CELLS = 100,
  parameter int IDX_W     = 7,
  parameter int CNT_W     = 8
) (
  input  logic           CLK,
  input  logic           RST_N,
  capp_tag_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] OP_NOP          = 3'b000;
  localparam logic [2:0] OP_LOAD         = 3'b001;
  localparam logic [2:0] OP_AND          = 3'b010;
  localparam logic [2:0] OP_OR           = 3'b011;
  localparam logic [2:0] OP_SELECT_FIRST = 3'b100;
  localparam logic [2:0] OP_CLEAR_FIRST  = 3'b101;
  localparam logic [2:0] OP_SET_ALL      = 3'b110;
  localparam logic [2:0] OP_CLEAR_ALL    = 3'b111;

  localparam logic [NUM_CELLS-1:0] ONE_V = NUM_CELLS'(1);

  state_e               state_q, state_d;
  logic [NUM_CELLS-1:0] tags_q, tags_d;
  logic [NUM_CELLS-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]     count_c;
  logic                 iter_valid_c;
  logic                 iter_done_c;

  // Priority encode toward the lowest index; only real cell indices can be returned
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CELLS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Population count of the tag register
  always_comb begin
    count_c = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      count_c = count_c + CNT_W'(tags_q[i]);
    end
  end

  // Tag op decode; ops are only honoured while the iterator is idle so tags stay frozen while busy
  always_comb begin
    tags_d = tags_q;
    if (bus.op_valid && (state_q == ST_IDLE)) begin
      case (bus.op)
        OP_NOP:          tags_d = tags_q;
        OP_LOAD:         tags_d = bus.match_lines;
        OP_AND:          tags_d = tags_q & bus.match_lines;
        OP_OR:           tags_d = tags_q | bus.match_lines;
        // x & -x isolates the lowest set bit and yields zero for zero input
        OP_SELECT_FIRST: tags_d = tags_q & (~tags_q + ONE_V);
        // x & (x-1) drops the lowest set bit and yields zero for zero input
        OP_CLEAR_FIRST:  tags_d = tags_q & (tags_q - ONE_V);
        OP_SET_ALL:      tags_d = '1;
        OP_CLEAR_ALL:    tags_d = '0;
        default:         tags_d = tags_q;
      endcase
    end
  end

  // Iterator next-state: snapshot tags into the shadow mask, then retire its lowest bit per handshake
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    iter_valid_c = 1'b0;
    iter_done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.iter_start) begin
          shadow_d = tags_q;
          state_d  = (|tags_q) ? ST_ITER : ST_DONE;
        end
      end
      ST_ITER: begin
        iter_valid_c = 1'b1;
        if (bus.iter_ready) begin
          shadow_d = shadow_q & (shadow_q - ONE_V);
          if (shadow_d == '0) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        iter_done_c = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        shadow_d = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset overriding everything
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      tags_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      tags_q   <= tags_d;
      shadow_q <= shadow_d;
    end
  end

  assign bus.tags       = tags_q;
  assign bus.some       = |tags_q;
  assign bus.none       = ~(|tags_q);
  assign bus.first_idx  = lowest_idx(tags_q);
  assign bus.tag_count  = count_c;
  assign bus.iter_valid = iter_valid_c;
  assign bus.iter_idx   = iter_valid_c ? lowest_idx(shadow_q) : '0;
  assign bus.iter_done  = iter_done_c;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule
